lift_apb_slave: RTL
===================

// Module: lift_apb_slave
// PURPOSE
//  APB slave register front-end of the car parking lift; the block the PREADY/WRITE/READ/PRESETn checks are bound to.
//  Decodes PCLK-domain APB transfers into 4 registers (0x00,0x01,0x02,0x04) and issues park/retrieve commands
//  to the lift motion controller over a valid/ready handshake. Collects completion status and raises irq_o.
// PARAMETERS
//  NUM_FLOORS  8   number of lift floors; floor fields are $clog2(NUM_FLOORS) wide, zero-extended to 8 bits
//  WAIT_MAX    15  max APB wait cycles on a GO write while the command channel is busy, then PSLVERR
// PORTS
//  PCLK          in   1  single clock, all logic rising-edge
//  PRESETn       in   1  asynchronous, active-low reset
//  PSELx_i       in   1  APB select
//  PENABLE_i     in   1  APB access phase
//  PWRITE_i      in   1  1=write, 0=read
//  PADDR_i       in   8  register address
//  PWDATA_i      in   8  write data
//  PREADY_o      out  1  transfer complete (high when idle)
//  PRDATA_o      out  8  read data
//  PSLVERR_o     out  1  error, valid with PREADY_o in access phase
//  cmd_valid_o   out  1  command to lift controller pending
//  cmd_ready_i   in   1  lift controller accepts command
//  cmd_op_o      out  1  0=park, 1=retrieve
//  cmd_floor_o   out  FW target floor
//  lift_busy_i   in   1  lift in motion
//  lift_floor_i  in   FW current floor
//  lift_done_i   in   1  1-cycle pulse: command finished
//  irq_o         out  1  interrupt, level
// BEHAVIOUR
//  Reset (async, PRESETn=0): PREADY_o=1, PRDATA_o=0, PSLVERR_o=0, cmd_valid_o=0, irq_o=0, all registers 0.
//  Map: 0x00 CTRL rw {irq_en[1],enable[0]}, bit2 GO write-only (reads 0); 0x01 TARGET rw floor;
//       0x02 STATUS {floor[7:3],err[2],done[1],busy[0]}, done/err W1C, busy/floor RO; 0x04 OP rw bit0.
//  APB FSM IDLE->SETUP (PSEL&!PENABLE)->ACCESS (PSEL&PENABLE)->IDLE. Zero-wait: PREADY_o=1 in ACCESS unless stalled.
//  Reads: PRDATA_o registered, valid in ACCESS cycle; PRDATA_o=0 outside ACCESS-read. Unmapped addr: read 0 + PSLVERR.
//  Unmapped write: no state change + PSLVERR. Write to TARGET >= NUM_FLOORS: ignored, STATUS.err=1, PSLVERR.
//  GO (CTRL write with bit2=1, enable=1): load cmd_floor_o=TARGET, cmd_op_o=OP, assert cmd_valid_o next cycle.
//  GO with enable=0: ignored, STATUS.err=1, no PSLVERR.
//  GO while cmd_valid_o=1: PREADY_o held low, wait counter increments; on cmd_ready_i release and complete next
//    cycle; if counter reaches WAIT_MAX, PREADY_o=1 + PSLVERR, GO dropped, STATUS.err=1.
//  cmd_valid_o held until cmd_valid_o&cmd_ready_i (one-cycle transfer); cmd fields stable while valid.
//  lift_done_i sets STATUS.done; same-cycle W1C and set: set wins.
//  irq_o = irq_en & (done|err), registered (1 cycle after flag set).
//  PSEL dropped mid-transfer: return to IDLE, no register update, stall counter cleared.
//  Reset mid-transfer or mid-handshake: immediate return to reset values; pending command lost.
// STRUCTURE
//  Package lift_pkg: address constants ADDR_CTRL/TARGET/STATUS/OP, CTRL/STATUS bit indices,
//    typedef enum {IDLE,SETUP,ACCESS} apb_state_e, typedef enum logic {OP_PARK,OP_RETRIEVE} lift_op_e.
//  Sub-module lift_cmd_chan: cmd holding register + valid/ready logic; top keeps APB FSM, regs, stall counter, irq.
// TESTING
//  Reset: PRESETn=0 with random APB inputs -> PREADY_o=1, PRDATA_o=0, irq_o=0, cmd_valid_o=0.
//  Write 0x01=0x05, 0x04=0x01, 0x00=0x07 -> cmd_valid_o=1 next cycle, cmd_floor_o=5, cmd_op_o=1; read 0x01 -> 0x05.
//  GO again with cmd_ready_i=0 for 3 cycles -> PREADY_o low 3 cycles, completes cycle after cmd_ready_i=1.
//  cmd_ready_i held 0 -> PSLVERR_o=1 with PREADY_o after WAIT_MAX(15) waits, STATUS read = err bit set (0x04).
//  lift_done_i pulse with irq_en=1 -> irq_o=1; write 0x02=0x02 -> done cleared, irq_o=0 next cycle.
//  Read 0x03, write 0x08, write TARGET=0x09 -> PSLVERR_o=1, PRDATA_o=0, no register change except STATUS.err.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared constants and types for the parking-lift APB front-end:
// register addresses, register bit positions and the FSM/command enums.
package lift_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_TARGET = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_OP     = 8'h04;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_GO     = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    typedef enum logic {OP_PARK, OP_RETRIEVE} lift_op_e;

    function automatic logic addr_mapped(input logic [7:0] addr);
        return addr inside {ADDR_CTRL, ADDR_TARGET, ADDR_STATUS, ADDR_OP};
    endfunction

endpackage

// File: rtl/lift_apb_slave_if.sv
// APB bus bundle between the host master and the lift register slave.
interface lift_apb_slave_if;

    logic       PSELx_i;
    logic       PENABLE_i;
    logic       PWRITE_i;
    logic [7:0] PADDR_i;
    logic [7:0] PWDATA_i;
    logic       PREADY_o;
    logic [7:0] PRDATA_o;
    logic       PSLVERR_o;

    modport master (
        output PSELx_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
        input  PREADY_o, PRDATA_o, PSLVERR_o
    );

    modport slave (
        input  PSELx_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
        output PREADY_o, PRDATA_o, PSLVERR_o
    );

endinterface

// File: rtl/lift_cmd_chan.sv
// Holding register for one park/retrieve command towards the motion
// controller; valid stays high and the fields stay frozen until accepted.
module lift_cmd_chan
    import lift_pkg::*;
#(
    parameter int FW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  lift_op_e      op_i,
    input  logic [FW-1:0] floor_i,
    input  logic          ready_i,
    output logic          valid_o,
    output lift_op_e      op_o,
    output logic [FW-1:0] floor_o
);

    logic          valid_q;
    lift_op_e      op_q;
    logic [FW-1:0] floor_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_PARK;
            floor_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            op_q    <= op_i;
            floor_q <= floor_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign floor_o = floor_q;

endmodule

// File: rtl/lift_apb_slave.sv
// APB register front-end of the parking lift: decodes CTRL/TARGET/STATUS/OP,
// issues GO commands through lift_cmd_chan and raises a level interrupt.
module lift_apb_slave
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int WAIT_MAX   = 15
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    lift_apb_slave_if.slave               apb,
    output logic                          cmd_valid_o,
    input  logic                          cmd_ready_i,
    output logic                          cmd_op_o,
    output logic [$clog2(NUM_FLOORS)-1:0] cmd_floor_o,
    input  logic                          lift_busy_i,
    input  logic [$clog2(NUM_FLOORS)-1:0] lift_floor_i,
    input  logic                          lift_done_i,
    output logic                          irq_o
);

    localparam int FW = $clog2(NUM_FLOORS);
    localparam int CW = $clog2(WAIT_MAX + 1);

    apb_state_e    state_q;
    logic          pready_q;
    logic          pslverr_q;
    logic [7:0]    prdata_q;
    logic [CW-1:0] wait_cnt_q;

    logic [1:0]    ctrl_q;
    logic [FW-1:0] target_q;
    logic          op_q;
    logic          done_q;
    logic          err_q;
    logic          irq_q;

    logic       setup_phase, commit, wr_ok;
    logic       target_ok, go_req, stall_req, setup_err;
    logic       wr_ctrl, wr_target, wr_status, wr_op, go_load, err_set;
    logic [7:0] rd_data;
    lift_op_e   cmd_op;

    assign setup_phase = apb.PSELx_i && !apb.PENABLE_i;
    assign commit      = (state_q != IDLE) && apb.PSELx_i && apb.PENABLE_i && pready_q;
    assign wr_ok       = commit && apb.PWRITE_i && !pslverr_q;

    assign target_ok = 32'(apb.PWDATA_i) < NUM_FLOORS;
    assign go_req    = apb.PWRITE_i && (apb.PADDR_i == ADDR_CTRL)
                       && apb.PWDATA_i[CTRL_GO] && apb.PWDATA_i[CTRL_EN];
    assign stall_req = go_req && cmd_valid_o && !cmd_ready_i;
    assign setup_err = !addr_mapped(apb.PADDR_i)
                       || (apb.PWRITE_i && (apb.PADDR_i == ADDR_TARGET) && !target_ok);

    assign wr_ctrl   = wr_ok && (apb.PADDR_i == ADDR_CTRL);
    assign wr_target = wr_ok && (apb.PADDR_i == ADDR_TARGET);
    assign wr_status = wr_ok && (apb.PADDR_i == ADDR_STATUS);
    assign wr_op     = wr_ok && (apb.PADDR_i == ADDR_OP);
    assign go_load   = wr_ctrl && apb.PWDATA_i[CTRL_GO] && apb.PWDATA_i[CTRL_EN];

    // An erroring CTRL write can only be a timed-out GO; both it and a bad
    // TARGET flag STATUS.err, an unmapped write leaves everything alone.
    assign err_set = (wr_ctrl && apb.PWDATA_i[CTRL_GO] && !apb.PWDATA_i[CTRL_EN])
                     || (commit && apb.PWRITE_i && pslverr_q
                         && (apb.PADDR_i == ADDR_TARGET || apb.PADDR_i == ADDR_CTRL));

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        rd_data = '0;
        case (apb.PADDR_i)
            ADDR_CTRL:   rd_data = {6'd0, ctrl_q};
            ADDR_TARGET: rd_data = 8'(target_q);
            ADDR_STATUS: rd_data = {5'(lift_floor_i), err_q, done_q, lift_busy_i};
            ADDR_OP:     rd_data = {7'd0, op_q};
            default:     rd_data = '0;
        endcase
    end

    // State names the last bus phase sampled: SETUP means the current cycle
    // is the first access cycle, ACCESS means the transfer is being extended.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            pready_q   <= 1'b1;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q   <= 1'b1;
                    pslverr_q  <= 1'b0;
                    prdata_q   <= '0;
                    wait_cnt_q <= '0;
                    if (setup_phase) begin
                        state_q   <= SETUP;
                        pready_q  <= !stall_req;
                        pslverr_q <= setup_err;
                        prdata_q  <= apb.PWRITE_i ? 8'd0 : rd_data;
                    end
                end
                default: begin
                    if (!apb.PSELx_i || (apb.PENABLE_i && pready_q)) begin
                        state_q    <= IDLE;
                        pready_q   <= 1'b1;
                        pslverr_q  <= 1'b0;
                        prdata_q   <= '0;
                        wait_cnt_q <= '0;
                    end else if (apb.PENABLE_i) begin
                        state_q <= ACCESS;
                        if (cmd_valid_o && cmd_ready_i) begin
                            pready_q <= 1'b1;
                        end else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Done: a set from the lift beats a same-cycle write-one-to-clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q   <= '0;
            target_q <= '0;
            op_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl)   ctrl_q   <= apb.PWDATA_i[1:0];
            if (wr_target) target_q <= apb.PWDATA_i[FW-1:0];
            if (wr_op)     op_q     <= apb.PWDATA_i[0];
            done_q <= lift_done_i || (done_q && !(wr_status && apb.PWDATA_i[STAT_DONE]));
            err_q  <= err_set || (err_q && !(wr_status && apb.PWDATA_i[STAT_ERR]));
            irq_q  <= ctrl_q[CTRL_IRQ_EN] && (done_q || err_q);
        end
    end

    lift_cmd_chan #(.FW(FW)) u_cmd_chan (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .load_i  (go_load),
        .op_i    (lift_op_e'(op_q)),
        .floor_i (target_q),
        .ready_i (cmd_ready_i),
        .valid_o (cmd_valid_o),
        .op_o    (cmd_op),
        .floor_o (cmd_floor_o)
    );

    assign cmd_op_o      = cmd_op;
    assign irq_o         = irq_q;
    assign apb.PREADY_o  = pready_q;
    assign apb.PSLVERR_o = pslverr_q;
    assign apb.PRDATA_o  = prdata_q;

endmodule
